// File: rtl/hpdl_pkg.sv
// Shared types and constants for the HPDL-1414 display controller.
package hpdl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BKSP  = 8'h08;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;

  localparam int NUM_POS = 16;
  localparam int POS_W   = 4;

  // Returns {found, index} of the first set bit of mask at or after 'from',
  // wrapping modulo NUM_POS. Scanning downwards lets the nearest hit win.
  function automatic logic [POS_W:0] first_dirty(input logic [NUM_POS-1:0] mask,
                                                 input logic [POS_W-1:0]   from);
    logic [POS_W:0]   res;
    logic [POS_W-1:0] idx;
    res = {1'b0, from};
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      idx = from + POS_W'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/hpdl_display_ctrl_write_fsm.sv
// Timed SETUP / STROBE / HOLD write sequencer for one HPDL-1414 character.
// Data, address and strobes are registered so the display pins never glitch.
module hpdl_write_fsm
  import hpdl_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [POS_W-1:0] pos,
  input  logic [6:0]       chr,
  output logic [6:0]       hpdl_d,
  output logic [1:0]       hpdl_a,
  output logic [3:0]       hpdl_wr_n,
  output logic             done
);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  sel;
  logic        load;

  // done means no write is in flight, so a new start is taken this cycle
  assign done = (state == S_IDLE);

  // State register, phase counter and registered display pins
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel       <= '0;
      hpdl_d    <= '0;
      hpdl_a    <= '0;
      hpdl_wr_n <= 4'hF;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        hpdl_d <= chr;
        hpdl_a <= ~pos[1:0];
        sel    <= pos[3:2];
      end
      hpdl_wr_n <= (state_nxt == S_STROBE) ? ~(4'b0001 << sel) : 4'hF;
    end
  end

  // Next-state: each timed phase counts down from its length minus one
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SETUP;
          cnt_nxt   = 16'(T_SETUP - 1);
          load      = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = 16'(T_PULSE - 1);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          state_nxt = S_HOLD;
          cnt_nxt   = 16'(T_HOLD - 1);
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 16'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/hpdl_display_ctrl.sv
// Terminal-style controller for a chain of four HPDL-1414 displays.
// Keeps a 16-character shadow buffer plus dirty mask and streams only
// changed positions to the display through the write sequencer.
module hpdl_display_ctrl
  import hpdl_pkg::*;
#(
  parameter int T_SETUP        = 2,
  parameter int T_PULSE        = 3,
  parameter int T_HOLD         = 2,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [6:0] hpdl_d,
  output logic [1:0] hpdl_a,
  output logic [3:0] hpdl_wr_n,
  output logic [4:0] cursor,
  output logic       busy
);

  logic [6:0]         buffer [NUM_POS];
  logic [NUM_POS-1:0] dirty, cmd_mask, set_mask, clr_mask;
  logic [POS_W-1:0]   rr_ptr, pick, wr_idx;
  logic [POS_W:0]     pick_res;
  logic [4:0]         cursor_nxt;
  logic [6:0]         print_ch, wr_val;
  logic               pick_vld, fsm_idle, start, accept, refresh_wrap;
  logic               is_print, wr_en, shift_en, clear_all;

  assign in_ready = (dirty == '0);
  assign accept   = in_valid && in_ready;
  assign busy     = !fsm_idle || (dirty != '0);

  assign pick_res = first_dirty(dirty, rr_ptr);
  assign pick_vld = pick_res[POS_W];
  assign pick     = pick_res[POS_W-1:0];
  assign start    = fsm_idle && pick_vld;
  assign clr_mask = start ? (NUM_POS'(1) << pick) : '0;
  assign set_mask = cmd_mask | {NUM_POS{refresh_wrap}};

  // Printable range detection; lower-case block folds onto upper case
  always_comb begin
    is_print = 1'b0;
    print_ch = in_data[6:0];
    if (in_data >= 8'h20 && in_data <= 8'h5F) begin
      is_print = 1'b1;
    end else if (in_data >= 8'h60 && in_data <= 8'h7F) begin
      is_print = 1'b1;
      print_ch = in_data[6:0] - 7'h20;
    end
  end

  // Command decode: buffer edits, newly dirtied positions, next cursor
  always_comb begin
    cmd_mask   = '0;
    cursor_nxt = cursor;
    wr_en      = 1'b0;
    wr_idx     = cursor[POS_W-1:0];
    wr_val     = print_ch;
    shift_en   = 1'b0;
    clear_all  = 1'b0;
    if (accept) begin
      if (is_print) begin
        if (cursor < 5'(NUM_POS)) begin
          wr_en      = 1'b1;
          cmd_mask   = NUM_POS'(1) << wr_idx;
          cursor_nxt = cursor + 5'd1;
        end else begin
          shift_en = 1'b1;
          cmd_mask = '1;
        end
      end else begin
        case (in_data)
          CH_BKSP: begin
            if (cursor != '0) begin
              wr_en      = 1'b1;
              wr_idx     = POS_W'(cursor - 5'd1);
              wr_val     = CH_SPACE[6:0];
              cmd_mask   = NUM_POS'(1) << wr_idx;
              cursor_nxt = cursor - 5'd1;
            end
          end
          CH_CR: cursor_nxt = '0;
          CH_FF: begin
            clear_all  = 1'b1;
            cmd_mask   = '1;
            cursor_nxt = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Control state: dirty mask (set beats clear), cursor, round-robin pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dirty  <= '1;
      cursor <= '0;
      rr_ptr <= '0;
    end else begin
      dirty  <= (dirty & ~clr_mask) | set_mask;
      cursor <= cursor_nxt;
      if (start) rr_ptr <= pick + POS_W'(1);
    end
  end

  // Shadow character buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_POS; i++) buffer[i] <= CH_SPACE[6:0];
    end else if (clear_all) begin
      for (int i = 0; i < NUM_POS; i++) buffer[i] <= CH_SPACE[6:0];
    end else if (shift_en) begin
      for (int i = 0; i < NUM_POS - 1; i++) buffer[i] <= buffer[i+1];
      buffer[NUM_POS-1] <= wr_val;
    end else if (wr_en) begin
      buffer[wr_idx] <= wr_val;
    end
  end

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      logic [RW-1:0] refresh_cnt;
      assign refresh_wrap = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
      // Free-running refresh period counter
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)               refresh_cnt <= '0;
        else if (refresh_wrap) refresh_cnt <= '0;
        else                   refresh_cnt <= refresh_cnt + RW'(1);
      end
    end else begin : g_no_refresh
      assign refresh_wrap = 1'b0;
    end
  endgenerate

  hpdl_write_fsm #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD)
  ) u_write_fsm (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .pos       (pick),
    .chr       (buffer[pick]),
    .hpdl_d    (hpdl_d),
    .hpdl_a    (hpdl_a),
    .hpdl_wr_n (hpdl_wr_n),
    .done      (fsm_idle)
  );

endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// Scoreboard bench for hpdl_display_ctrl: stimulus pushes the expected
// display writes, a monitor pops and compares each strobe as it appears.
module tb_hpdl_display_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [6:0] hpdl_d;
  logic [1:0] hpdl_a;
  logic [3:0] hpdl_wr_n;
  logic [4:0] cursor;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [12:0] sb [$];

  hpdl_display_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .hpdl_d    (hpdl_d),
    .hpdl_a    (hpdl_a),
    .hpdl_wr_n (hpdl_wr_n),
    .cursor    (cursor),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Expected write word {wr_n, a, d} for position p
  function automatic logic [12:0] exp_w(input int p, input logic [6:0] d);
    logic [3:0] pp;
    logic [3:0] wr;
    pp = 4'(p);
    wr = ~(4'b0001 << pp[3:2]);
    return {wr, ~pp[1:0], d};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 expected 1 (byte 0x%0h)", b);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=1 expected 0");
    end
  endtask

  // Monitor: check each strobe against the scoreboard, its width and spacing
  int          cyc = 0;
  int          last_start = 0;
  bit          last_vld = 1'b0;
  int          low_cnt = 0;
  logic [3:0]  prev_wr = 4'hF;
  logic [12:0] e;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      prev_wr  = 4'hF;
      low_cnt  = 0;
      last_vld = 1'b0;
    end else begin
      if (hpdl_wr_n != 4'hF) begin
        if (prev_wr == 4'hF) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got wr_n=%b a=%b d=0x%0h expected none",
                     hpdl_wr_n, hpdl_a, hpdl_d);
          end else begin
            e = sb.pop_front();
            if ({hpdl_wr_n, hpdl_a, hpdl_d} != e) begin
              n_fail++;
              $display("FAIL write: got wr_n=%b a=%b d=0x%0h expected wr_n=%b a=%b d=0x%0h",
                       hpdl_wr_n, hpdl_a, hpdl_d, e[12:9], e[8:7], e[6:0]);
            end
          end
          if (last_vld && (cyc - last_start) < 10)
            chk("write_spacing", cyc - last_start, 8);
          last_start = cyc;
          last_vld   = 1'b1;
          low_cnt    = 1;
        end else begin
          low_cnt++;
        end
      end else if (prev_wr != 4'hF) begin
        chk("strobe_width", low_cnt, 3);
      end
      prev_wr = hpdl_wr_n;
    end
  end

  initial begin
    int n;

    // Reset and blanking flush
    #1 RST = 1'b1;
    #3;
    chk("rst_wr_n", hpdl_wr_n, 4'hF);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_d", hpdl_d, 0);
    chk("rst_a", hpdl_a, 0);
    chk("rst_busy", busy, 1);
    for (int p = 0; p < 16; p++) sb.push_back(exp_w(p, 7'h20));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_after_flush", in_ready, 1);
    chk("ready_at_last_pick", sb.size(), 1);
    wait_idle();
    chk("blank_sb_empty", sb.size(), 0);

    // Lower-case 'a' folds to 'A' at position 0
    sb.push_back({4'b1110, 2'b11, 7'h41});
    send(8'h61);
    wait_idle();
    chk("a_cursor", cursor, 1);

    // CR, then fill all 16, then a scroll with 'A' and one with 'B'
    send(8'h0D);
    for (int p = 0; p < 16; p++) begin
      sb.push_back(exp_w(p, 7'h41));
      send(8'h41);
    end
    wait_idle();
    chk("fill_cursor", cursor, 16);
    for (int p = 0; p < 16; p++) sb.push_back(exp_w(p, 7'h41));
    send(8'h41);
    wait_idle();
    for (int p = 0; p < 16; p++) sb.push_back(exp_w(p, (p == 15) ? 7'h42 : 7'h41));
    send(8'h42);
    wait_idle();
    chk("scroll_cursor", cursor, 16);
    chk("scroll_sb_empty", sb.size(), 0);

    // Form feed clears everything
    for (int p = 0; p < 16; p++) sb.push_back(exp_w(p, 7'h20));
    send(8'h0C);
    wait_idle();
    chk("ff_cursor", cursor, 0);

    // Backspace at cursor 0 does nothing
    send(8'h08);
    repeat (20) @(negedge CLK);
    chk("bksp0_cursor", cursor, 0);
    chk("bksp0_ready", in_ready, 1);
    chk("bksp0_busy", busy, 0);

    // Five characters then backspace blanks position 4
    for (int p = 0; p < 5; p++) begin
      sb.push_back(exp_w(p, 7'(8'h31 + p)));
      send(8'(8'h31 + p));
    end
    wait_idle();
    chk("five_cursor", cursor, 5);
    sb.push_back({4'b1101, 2'b11, 7'h20});
    send(8'h08);
    wait_idle();
    chk("bksp_cursor", cursor, 4);

    // Advance to position 8 and reset in the middle of its strobe
    for (int p = 4; p < 9; p++) begin
      sb.push_back(exp_w(p, 7'(8'h32 + p)));
      send(8'(8'h32 + p));
    end
    n = 0;
    while (hpdl_wr_n != 4'b1011 && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("pre_rst_strobe", hpdl_wr_n, 4'b1011);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_wr_n", hpdl_wr_n, 4'hF);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_cursor", cursor, 0);
    @(negedge CLK);
    sb.delete();
    for (int p = 0; p < 16; p++) sb.push_back(exp_w(p, 7'h20));
    @(negedge CLK);
    RST = 1'b0;
    wait_idle();
    chk("reblank_sb_empty", sb.size(), 0);
    chk("end_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
